reg_select_sb: RTL and testbench
================================

# reg_select_sb

Parametrised register select/encode unit with a write-pending scoreboard for the datapath register file. It latches the instruction register, extracts the Ra/Rb/Rc fields, and decodes the selected field into registered one-hot `reg_in`/`reg_out` enables. It tracks registers with outstanding writebacks and stalls reads of them. It sits between the control unit and the register file, and adds selectable R0 write protection and conflict reporting.

## Interface
- `NREGS`, 16: number of general registers; power of two, 2..64.
- `IDXW`, `$clog2(NREGS)`: register index width.
- `IRW`, 32: instruction width.
- `RA_LSB`, 23: LSB of the Ra field; field is `IR[RA_LSB+IDXW-1:RA_LSB]`.
- `RB_LSB`, 19: LSB of the Rb field.
- `RC_LSB`, 15: LSB of the Rc field.
- `R0_WRITABLE`, 1: when 0, writes and issues targeting R0 are suppressed.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `clr`  in  1  reset; synchronous, active-high.
- `ir_ld`  in  1  latch `ir_in` into the internal IR.
- `ir_in`  in  IRW  instruction word.
- `Gra`, `Grb`, `Grc`  in  1  field select; priority is Gra > Grb > Grc.
- `Rin`  in  1  request a write enable for the selected register.
- `Rout`  in  1  request a read enable for the selected register.
- `BAout`  in  1  base-address read; when the selected register is R0, the read yields zero.
- `issue`  in  1  mark the Ra register of the latched IR as pending.
- `wb_valid`  in  1  writeback complete.
- `wb_idx`  in  IDXW  index of the register being written back.
- `reg_in`  out  NREGS  registered one-hot write enables.
- `reg_out`  out  NREGS  registered one-hot read enables.
- `ba_zero`  out  1  registered; the bus must drive 0 this cycle.
- `sel_idx`  out  IDXW  combinational currently selected index.
- `stall`  out  1  combinational read-after-pending hazard.
- `pending`  out  NREGS  scoreboard state.
- `err_conflict`  out  1  registered one-cycle pulse flagging an illegal control combination.

## Operation
- IR: loads on `ir_ld`; otherwise holds. Fields are always decoded from the latched IR, never from `ir_in`.
- Selection: `sel_idx` is taken from the field of the highest-priority asserted G signal.
  - `sel_valid` = Gra|Grb|Grc.
  - With no G asserted there is no selection, and both enable vectors go to 0 next cycle. The previous selection is not held.
- Next-state enables, computed each cycle:
  - Rin & sel_valid & !(sel_idx==0 & !R0_WRITABLE) → `reg_in` = onehot(sel_idx); otherwise 0.
  - (Rout|BAout) & sel_valid & !Rin & !stall → `reg_out` = onehot(sel_idx), except BAout with sel_idx==0, which gives `reg_out`=0 and `ba_zero`=1.
  - Rin together with Rout or BAout: Rin wins, the read is dropped, and `err_conflict`=1 next cycle.
  - More than one G asserted: priority applies, and `err_conflict`=1 next cycle.
- Scoreboard:
  - `issue` sets pending[Ra], except Ra==0 when R0_WRITABLE=0, which is ignored.
  - `wb_valid` clears pending[wb_idx].
  - Same index set and cleared in the same cycle: set wins, because a new write is outstanding.
  - `issue` on an index that is already pending leaves it pending. There is no counting.
- Stall: `stall` = (Rout|BAout) & sel_valid & pending[sel_idx] & !(wb_valid & wb_idx==sel_idx).
  - A writeback in the same cycle bypasses the stall.
  - BAout on R0 never stalls.
- Out-of-range indices cannot occur because NREGS = 2^IDXW.

## Timing
- Reset state (synchronous `clr`): IR=0, `reg_in`=0, `reg_out`=0, `ba_zero`=0, `pending`=0, `err_conflict`=0.
- While `clr` is high all other inputs are ignored. Reset mid-operation drops every pending bit at the next edge.
- Latency:
  - Control inputs to `reg_in`/`reg_out`/`ba_zero`/`err_conflict`: 1 cycle.
  - `sel_idx` and `stall`: 0 cycles, combinational.
- `ir_ld` and a selection in the same cycle: the selection decodes the old IR, and the new IR is visible the following cycle.
- `issue` takes effect at the edge, so `pending` and `stall` reflect it from the next cycle.
- `issue` and `ir_ld` in the same cycle: Ra comes from the old IR.
- A stalled read produces `reg_out`=0 for the following cycle. The control unit holds Rout until `stall` deasserts; the block does not replay reads.

## Structure
- Shared package `cpu_pkg`: `NREGS_DEFAULT`, the field LSB constants, `reg_idx_t`, and a `onehot` function.
- One natural sub-module, `onehot_dec` (parameter `IDXW`, enable input, one-hot output). It is instantiated twice: once for the write path and once for the read path.
- The scoreboard stays inline as a NREGS-bit register with per-bit set/clear logic.

## Test plan
- Reset: `clr`=1 with all controls high → all outputs 0 for that cycle and the next; `pending`=0.
- Decode: load IR with Ra=5, Rb=9, Rc=12, then Grb+Rout → `reg_out`=16'h0200 one cycle later. With Gra+Grc+Rin → `reg_in`=16'h0020 and `err_conflict`=1.
- BAout and protection: Ra=0 with Gra+BAout → `reg_out`=0, `ba_zero`=1. With R0_WRITABLE=0, Gra+Rin → `reg_in`=0.
- Scoreboard: issue with Ra=3; next cycle Gra+Rout → `stall`=1 and `reg_out`=0. Then `wb_valid` with `wb_idx`=3 in the same cycle → `stall`=0 and `reg_out`=16'h0008 next cycle.
- Set/clear collision: `issue` (Ra=7) together with `wb_valid`/`wb_idx`=7 while pending[7]=1 → pending[7] stays 1.
- Parametrisation: with NREGS=32, IDXW=5, Ra=31 and Gra+Rin → `reg_in`=32'h8000_0000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the register select / scoreboard slice.
// Latency: n/a (constants, types and a pure function only).
// Backpressure: n/a.
package cpu_pkg;

   localparam int NREGS_DEFAULT  = 16;
   localparam int IDXW_DEFAULT   = $clog2(NREGS_DEFAULT);
   localparam int IRW_DEFAULT    = 32;
   localparam int RA_LSB_DEFAULT = 23;
   localparam int RB_LSB_DEFAULT = 19;
   localparam int RC_LSB_DEFAULT = 15;

   // Largest register file supported is 64 entries (6-bit index).
   localparam int MAX_IDXW = 6;

   typedef logic [IDXW_DEFAULT-1:0] reg_idx_t;

   // One-hot of an index at the maximum width; callers size-cast the result
   // down to their own register count.
   function automatic logic [(1<<MAX_IDXW)-1:0] onehot(input logic [MAX_IDXW-1:0] idx);
      return {{((1<<MAX_IDXW)-1){1'b0}}, 1'b1} << idx;
   endfunction

endpackage

// File: rtl/onehot_dec.sv
// Gated index-to-one-hot decoder.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; output is all zeros whenever en is low.
// Ports: en (gate), idx (IDXW-bit index), oh (2**IDXW one-hot vector).
module onehot_dec
   import cpu_pkg::*;
#(
   parameter int IDXW = 4
) (
   input  logic                  en,
   input  logic [IDXW-1:0]       idx,
   output logic [(1<<IDXW)-1:0]  oh
);

   localparam int N = 1 << IDXW;

   always_comb begin
      oh = '0;
      if (en) begin
         oh = N'(onehot(MAX_IDXW'(idx)));
      end
   end

endmodule

// File: rtl/reg_select_sb.sv
// Register select/encode unit with write-pending scoreboard for the register file.
// Latency: reg_in/reg_out/ba_zero/err_conflict 1 cycle; sel_idx/stall combinational.
// Backpressure: reads of pending registers raise stall and are dropped; the control unit re-presents them.
// Ports: clk/clr (sync active-high), ir_ld/ir_in (IR load), Gra/Grb/Grc (field select),
//        Rin/Rout/BAout (enable requests), issue (mark Ra pending), wb_valid/wb_idx (writeback),
//        reg_in/reg_out/ba_zero/err_conflict (registered), sel_idx/stall (comb), pending (scoreboard).
module reg_select_sb
   import cpu_pkg::*;
#(
   parameter int NREGS       = NREGS_DEFAULT,
   parameter int IDXW        = $clog2(NREGS),
   parameter int IRW         = IRW_DEFAULT,
   parameter int RA_LSB      = RA_LSB_DEFAULT,
   parameter int RB_LSB      = RB_LSB_DEFAULT,
   parameter int RC_LSB      = RC_LSB_DEFAULT,
   parameter int R0_WRITABLE = 1
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             ir_ld,
   input  logic [IRW-1:0]   ir_in,
   input  logic             Gra,
   input  logic             Grb,
   input  logic             Grc,
   input  logic             Rin,
   input  logic             Rout,
   input  logic             BAout,
   input  logic             issue,
   input  logic             wb_valid,
   input  logic [IDXW-1:0]  wb_idx,
   output logic [NREGS-1:0] reg_in,
   output logic [NREGS-1:0] reg_out,
   output logic             ba_zero,
   output logic [IDXW-1:0]  sel_idx,
   output logic             stall,
   output logic [NREGS-1:0] pending,
   output logic             err_conflict
);

   localparam logic R0_PROT = (R0_WRITABLE == 0);

   logic [IRW-1:0]   ir_q;
   logic [IDXW-1:0]  ra, rb, rc;
   logic             sel_valid, multi_g, rd_req, ba_r0;
   logic             wr_ok, rd_ok, bypass;
   logic [NREGS-1:0] reg_in_d, reg_out_d, pend_set, pend_clr;
   logic             unused_ir_bits;

   // Only the register fields of the IR are consumed here.
   assign unused_ir_bits = ^ir_q;

   assign ra = ir_q[RA_LSB +: IDXW];
   assign rb = ir_q[RB_LSB +: IDXW];
   assign rc = ir_q[RC_LSB +: IDXW];

   always_comb begin
      sel_idx = '0;
      if (Gra)      sel_idx = ra;
      else if (Grb) sel_idx = rb;
      else if (Grc) sel_idx = rc;
   end

   assign sel_valid = Gra | Grb | Grc;
   assign multi_g   = (Gra & Grb) | (Gra & Grc) | (Grb & Grc);
   assign rd_req    = Rout | BAout;
   // A base-address read of R0 is answered by forcing zero on the bus, so it
   // never needs the register and never waits on the scoreboard.
   assign ba_r0     = BAout & (sel_idx == '0);
   assign bypass    = wb_valid & (wb_idx == sel_idx);
   assign stall     = rd_req & sel_valid & pending[sel_idx] & ~bypass & ~ba_r0;

   assign wr_ok = Rin & sel_valid & ~(R0_PROT & (sel_idx == '0));
   // Rin has priority over any read in the same cycle.
   assign rd_ok = rd_req & sel_valid & ~Rin & ~stall;

   onehot_dec #(.IDXW(IDXW)) u_dec_wr (
      .en  (wr_ok),
      .idx (sel_idx),
      .oh  (reg_in_d)
   );

   onehot_dec #(.IDXW(IDXW)) u_dec_rd (
      .en  (rd_ok & ~ba_r0),
      .idx (sel_idx),
      .oh  (reg_out_d)
   );

   always_comb begin
      pend_set = '0;
      pend_clr = '0;
      if (issue && !(R0_PROT && (ra == '0))) pend_set = NREGS'(onehot(MAX_IDXW'(ra)));
      if (wb_valid)                          pend_clr = NREGS'(onehot(MAX_IDXW'(wb_idx)));
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         ir_q         <= '0;
         reg_in       <= '0;
         reg_out      <= '0;
         ba_zero      <= 1'b0;
         pending      <= '0;
         err_conflict <= 1'b0;
      end else begin
         if (ir_ld) ir_q <= ir_in;
         reg_in       <= reg_in_d;
         reg_out      <= reg_out_d;
         ba_zero      <= rd_ok & ba_r0;
         // Set after clear: a fresh issue outranks a retiring writeback.
         pending      <= (pending & ~pend_clr) | pend_set;
         err_conflict <= (Rin & rd_req) | multi_g;
      end
   end

endmodule

// File: tb/tb_reg_select_sb.sv
module tb_reg_select_sb;

   logic        clk = 1'b0;
   logic        clr, ir_ld, Gra, Grb, Grc, Rin, Rout, BAout, issue, wb_valid;
   logic [31:0] ir_in;
   logic [5:0]  wb_idx_v;

   always #5 clk = ~clk;

   // Three configurations: default, R0 write-protected, 32 registers.
   logic [15:0] rin0, rout0, pend0, rin1, rout1, pend1;
   logic [31:0] rin2, rout2, pend2;
   logic [3:0]  sel0, sel1;
   logic [4:0]  sel2;
   logic        st0, st1, st2, bz0, bz1, bz2, er0, er1, er2;

   reg_select_sb dut0 (
      .clk(clk), .clr(clr), .ir_ld(ir_ld), .ir_in(ir_in), .Gra(Gra), .Grb(Grb), .Grc(Grc),
      .Rin(Rin), .Rout(Rout), .BAout(BAout), .issue(issue), .wb_valid(wb_valid),
      .wb_idx(wb_idx_v[3:0]), .reg_in(rin0), .reg_out(rout0), .ba_zero(bz0), .sel_idx(sel0),
      .stall(st0), .pending(pend0), .err_conflict(er0));

   reg_select_sb #(.R0_WRITABLE(0)) dut1 (
      .clk(clk), .clr(clr), .ir_ld(ir_ld), .ir_in(ir_in), .Gra(Gra), .Grb(Grb), .Grc(Grc),
      .Rin(Rin), .Rout(Rout), .BAout(BAout), .issue(issue), .wb_valid(wb_valid),
      .wb_idx(wb_idx_v[3:0]), .reg_in(rin1), .reg_out(rout1), .ba_zero(bz1), .sel_idx(sel1),
      .stall(st1), .pending(pend1), .err_conflict(er1));

   reg_select_sb #(.NREGS(32)) dut2 (
      .clk(clk), .clr(clr), .ir_ld(ir_ld), .ir_in(ir_in), .Gra(Gra), .Grb(Grb), .Grc(Grc),
      .Rin(Rin), .Rout(Rout), .BAout(BAout), .issue(issue), .wb_valid(wb_valid),
      .wb_idx(wb_idx_v[4:0]), .reg_in(rin2), .reg_out(rout2), .ba_zero(bz2), .sel_idx(sel2),
      .stall(st2), .pending(pend2), .err_conflict(er2));

   logic [63:0] o_rin[3], o_rout[3], o_pend[3];
   logic [5:0]  o_sel[3];
   logic        o_stall[3], o_bz[3], o_err[3];

   assign o_rin[0] = 64'(rin0);   assign o_rin[1] = 64'(rin1);   assign o_rin[2] = 64'(rin2);
   assign o_rout[0] = 64'(rout0); assign o_rout[1] = 64'(rout1); assign o_rout[2] = 64'(rout2);
   assign o_pend[0] = 64'(pend0); assign o_pend[1] = 64'(pend1); assign o_pend[2] = 64'(pend2);
   assign o_sel[0] = 6'(sel0);    assign o_sel[1] = 6'(sel1);    assign o_sel[2] = 6'(sel2);
   assign o_stall[0] = st0;       assign o_stall[1] = st1;       assign o_stall[2] = st2;
   assign o_bz[0] = bz0;          assign o_bz[1] = bz1;          assign o_bz[2] = bz2;
   assign o_err[0] = er0;         assign o_err[1] = er1;         assign o_err[2] = er2;

   // Reference model state
   int          nr[3]  = '{16, 16, 32};
   bit          r0w[3] = '{1'b1, 1'b0, 1'b1};
   logic [31:0] m_ir[3];
   logic [63:0] m_pend[3], m_rin[3], m_rout[3];
   bit          m_bz[3], m_err[3];
   bit          model_valid = 1'b0;

   int n_vec = 0;
   int n_mis = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic idle();
      clr = 0; ir_ld = 0; ir_in = '0; Gra = 0; Grb = 0; Grc = 0;
      Rin = 0; Rout = 0; BAout = 0; issue = 0; wb_valid = 0; wb_idx_v = '0;
   endtask

   // One clock: combinational checks before the edge, registered checks after.
   task automatic step();
      logic [31:0] n_ir[3];
      logic [63:0] n_pend[3], n_rin[3], n_rout[3];
      bit          n_bz[3], n_err[3];
      #1;
      for (int k = 0; k < 3; k++) begin
         int  nm, ra, rb, rc, sel, wbi, ng;
         bit  sv, rd, bar0, stl, rdok;
         nm   = nr[k] - 1;
         ra   = int'(m_ir[k] >> 23) & nm;
         rb   = int'(m_ir[k] >> 19) & nm;
         rc   = int'(m_ir[k] >> 15) & nm;
         sv   = Gra | Grb | Grc;
         sel  = Gra ? ra : Grb ? rb : Grc ? rc : 0;
         wbi  = int'(wb_idx_v) & nm;
         rd   = Rout | BAout;
         bar0 = BAout && sel == 0;
         stl  = rd && sv && m_pend[k][sel] && !(wb_valid && wbi == sel) && !bar0;
         if (model_valid) begin
            chk($sformatf("sel_idx[%0d]", k), 64'(o_sel[k]), 64'(sel));
            chk($sformatf("stall[%0d]", k), 64'(o_stall[k]), 64'(stl));
         end
         ng   = int'(Gra) + int'(Grb) + int'(Grc);
         rdok = rd && sv && !Rin && !stl;
         if (clr) begin
            n_ir[k] = '0; n_pend[k] = '0; n_rin[k] = '0; n_rout[k] = '0; n_bz[k] = 0; n_err[k] = 0;
         end else begin
            n_ir[k]   = ir_ld ? ir_in : m_ir[k];
            n_rin[k]  = (Rin && sv && !(sel == 0 && !r0w[k])) ? (64'd1 << sel) : 64'd0;
            n_rout[k] = (rdok && !bar0) ? (64'd1 << sel) : 64'd0;
            n_bz[k]   = rdok && bar0;
            n_err[k]  = (Rin && rd) || ng > 1;
            n_pend[k] = m_pend[k];
            if (wb_valid) n_pend[k][wbi] = 1'b0;
            if (issue && !(ra == 0 && !r0w[k])) n_pend[k][ra] = 1'b1;
         end
      end
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
         m_ir[k] = n_ir[k]; m_pend[k] = n_pend[k]; m_rin[k] = n_rin[k];
         m_rout[k] = n_rout[k]; m_bz[k] = n_bz[k]; m_err[k] = n_err[k];
      end
      if (clr) model_valid = 1'b1;
      #1;
      if (model_valid) begin
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("reg_in[%0d]", k), o_rin[k], m_rin[k]);
            chk($sformatf("reg_out[%0d]", k), o_rout[k], m_rout[k]);
            chk($sformatf("ba_zero[%0d]", k), 64'(o_bz[k]), 64'(m_bz[k]));
            chk($sformatf("err_conflict[%0d]", k), 64'(o_err[k]), 64'(m_err[k]));
            chk($sformatf("pending[%0d]", k), o_pend[k], m_pend[k]);
         end
      end
   endtask

   task automatic load_ir(input logic [31:0] v);
      idle(); ir_ld = 1; ir_in = v; step();
   endtask

   initial begin
      idle();
      // Reset with every control asserted
      clr = 1; ir_ld = 1; ir_in = '1; Gra = 1; Grb = 1; Grc = 1; Rin = 1; Rout = 1;
      BAout = 1; issue = 1; wb_valid = 1;
      step();
      chk("rst reg_in", o_rin[0], 64'd0);
      chk("rst pending", o_pend[0], 64'd0);
      step();
      chk("rst2 err", 64'(o_err[0]), 64'd0);
      idle(); step();

      // Decode: Ra=5, Rb=9, Rc=12
      load_ir((32'd5 << 23) | (32'd9 << 19) | (32'd12 << 15));
      idle(); Grb = 1; Rout = 1; step();
      chk("dec Rb reg_out", o_rout[0], 64'h0200);
      idle(); Gra = 1; Grc = 1; Rin = 1; step();
      chk("dec Ra reg_in", o_rin[0], 64'h0020);
      chk("dec multi-G err", 64'(o_err[0]), 64'd1);

      // BAout on R0 and R0 write protection
      load_ir(32'd0);
      idle(); Gra = 1; BAout = 1; step();
      chk("ba r0 reg_out", o_rout[0], 64'd0);
      chk("ba r0 ba_zero", 64'(o_bz[0]), 64'd1);
      idle(); Gra = 1; Rin = 1; step();
      chk("r0 prot reg_in", o_rin[1], 64'd0);
      chk("r0 open reg_in", o_rin[0], 64'd1);

      // Scoreboard stall and writeback bypass
      load_ir(32'd3 << 23);
      idle(); issue = 1; step();
      idle(); Gra = 1; Rout = 1; #1;
      chk("sb stall", 64'(o_stall[0]), 64'd1);
      step();
      chk("sb stalled reg_out", o_rout[0], 64'd0);
      idle(); Gra = 1; Rout = 1; wb_valid = 1; wb_idx_v = 6'd3; #1;
      chk("sb bypass stall", 64'(o_stall[0]), 64'd0);
      step();
      chk("sb bypass reg_out", o_rout[0], 64'h0008);

      // Set/clear collision on an already pending register
      load_ir(32'd7 << 23);
      idle(); issue = 1; step();
      idle(); issue = 1; wb_valid = 1; wb_idx_v = 6'd7; step();
      chk("collision pending7", 64'(o_pend[0][7]), 64'd1);

      // 32-register configuration, top register
      load_ir(32'd31 << 23);
      idle(); Gra = 1; Rin = 1; step();
      chk("nregs32 reg_in", o_rin[2], 64'h8000_0000);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] v;
         v = $urandom;
         if ($urandom_range(0, 2) == 0) v[27:23] = 5'($urandom_range(0, 3));
         if ($urandom_range(0, 2) == 0) v[22:19] = 4'($urandom_range(0, 3));
         if ($urandom_range(0, 2) == 0) v[18:15] = 4'($urandom_range(0, 3));
         clr      = ($urandom_range(0, 59) == 0);
         ir_ld    = ($urandom_range(0, 3) == 0);
         ir_in    = v;
         Gra      = ($urandom_range(0, 2) == 0);
         Grb      = ($urandom_range(0, 2) == 0);
         Grc      = ($urandom_range(0, 2) == 0);
         Rin      = ($urandom_range(0, 3) == 0);
         Rout     = ($urandom_range(0, 1) == 0);
         BAout    = ($urandom_range(0, 3) == 0);
         issue    = ($urandom_range(0, 1) == 0);
         wb_valid = ($urandom_range(0, 2) == 0);
         wb_idx_v = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 3)) : 6'($urandom);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
